wb_rr_arbiter: RTL
==================

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be: ADDR_WIDTH, 32, address bits; DATA_WIDTH, 32, data bits (8/16/32/64); SELECT_WIDTH, DATA_WIDTH/8, byte selects; TIMEOUT_CYCLES, 16, response watchdog limit (0 disables).
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 mN_adr_i, mN_dat_i, mN_sel_i (N=0,1)  input  ADDR_WIDTH/DATA_WIDTH/SELECT_WIDTH  master N address, write data, byte selects.
REQ-005 mN_we_i, mN_stb_i, mN_cyc_i  input  1 each  master N write enable, strobe, cycle.
REQ-006 mN_dat_o  output  DATA_WIDTH  read data to master N.
REQ-007 mN_ack_o, mN_err_o, mN_rty_o  output  1 each  terminations to master N.
REQ-008 s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o  output  matching widths  shared slave request.
REQ-009 s_dat_i, s_ack_i, s_err_i, s_rty_i  input  matching widths  shared slave response.

Function
REQ-010 FSM states: IDLE, OWN0, OWN1; state and last-owner pointer (last) SHALL be registered.
REQ-011 IDLE: only mN_cyc_i high -> OWNN next cycle; both high -> OWN of master != last; neither -> stay IDLE.
REQ-012 Grant latency: mN_cyc_i rising in IDLE -> s_cyc_o high exactly one cycle later.
REQ-013 OWNN: s_adr/dat/sel/we/stb/cyc_o SHALL equal master N inputs combinationally; s_dat_i/ack/err/rty routed to master N only.
REQ-014 Non-owning master and all masters in IDLE: dat_o=0, ack/err/rty_o=0; in IDLE all s_* outputs=0.
REQ-015 OWNN with mN_cyc_i low -> IDLE next cycle, last<=N; cycle in which cyc_i is low SHALL drive s_cyc_o=0 (one bubble cycle between owners).
REQ-016 Ownership SHALL never change while owner's cyc_i high (bursts/RMW atomic).
REQ-017 Watchdog counter SHALL increment each cycle s_cyc_o&s_stb_o high with no s_ack/err/rty_i; clear on any response, on stb low, or on state change.
REQ-018 Counter reaching TIMEOUT_CYCLES (non-zero): mN_err_o high one cycle, s_stb_o forced 0 that cycle, counter cleared; counter width $clog2(TIMEOUT_CYCLES+1).
REQ-019 Slave response and timeout in same cycle: response forwarded, no err generated.
REQ-020 Slave response arriving in IDLE or after owner dropped cyc SHALL be discarded.

Reset
REQ-021 rst low SHALL immediately force state=IDLE, last=1 (m0 wins first tie), counter=0, hence all outputs 0, regardless of transfer in progress.
REQ-022 First grant after rst release SHALL follow REQ-011/012 with no extra delay.

Structure
REQ-023 Package wb_arb_pkg SHALL hold the state enum typedef and default parameter constants.
REQ-024 Watchdog SHALL be sub-module wb_arb_timeout (inputs: clk, rst, active, resp, clr; output: expired).
REQ-025 Request/response muxing SHALL be combinational in the top module; no datapath registers.

Verification
REQ-026 m0 single write adr=0x100 dat=0xDEADBEEF, slave ack after 2 cycles -> s_cyc_o one cycle after m0_cyc_i, m0_ack_o one cycle, m1 sees nothing.
REQ-027 m0,m1 cyc rise same cycle after reset -> m0 granted; m0 releases -> one IDLE cycle -> m1 granted; next tie -> m0.
REQ-028 m1 4-beat burst while m0 requests -> m1 keeps grant all beats; m0 granted only after m1_cyc_i low.
REQ-029 Slave never responds, TIMEOUT_CYCLES=16 -> owner err_o pulses on 16th stalled cycle, s_stb_o low that cycle; ack on same cycle as expiry -> ack only.
REQ-030 rst low mid-burst -> all outputs 0 same cycle; after release, pending cyc grants in one cycle; late s_ack_i in IDLE not forwarded.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state type, default parameters and helpers for the round-robin Wishbone arbiter
package wb_arb_pkg;
    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 16;
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_e;
    function automatic int cnt_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction
endpackage

// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if: one Wishbone link
//   master modport drives adr/dat_w/sel/we/stb/cyc, slave modport drives dat_r/ack/err/rty
interface wb_rr_arbiter_if
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0]   adr;
    logic [DATA_WIDTH-1:0]   dat_w;
    logic [DATA_WIDTH-1:0]   dat_r;
    logic [SELECT_WIDTH-1:0] sel;
    logic                    we;
    logic                    stb;
    logic                    cyc;
    logic                    ack;
    logic                    err;
    logic                    rty;
    modport master (output adr, dat_w, sel, we, stb, cyc, input dat_r, ack, err, rty);
    modport slave  (input adr, dat_w, sel, we, stb, cyc, output dat_r, ack, err, rty);
endinterface

// File: rtl/wb_arb_timeout.sv
// wb_arb_timeout: response watchdog for the arbiter
//   clk, rst_n : clock, async active-low reset
//   active     : request strobed on the slave bus this cycle
//   resp       : slave ack/err/rty this cycle
//   clr        : arbiter state is changing
//   expired    : this is the TIMEOUT_CYCLES-th consecutive stalled cycle
module wb_arb_timeout
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic resp,
    input  logic clr,
    output logic expired
);
    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    // counter holds the number of stalled cycles already seen, so the limit hits on the last one
    assign expired = (TIMEOUT_CYCLES != 0) && active && !resp && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else
            r_cnt <= (clr || !active || resp || expired) ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-master round-robin Wishbone arbiter with response watchdog
//   clk, rst_n : clock, async active-low reset
//   m0, m1     : master links (arbiter is their slave)
//   s          : shared slave link (arbiter is its master)
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_rr_arbiter_if.slave  m0,
    wb_rr_arbiter_if.slave  m1,
    wb_rr_arbiter_if.master s
);
    arb_state_e              r_state;
    logic                    r_last;
    logic                    w_own0;
    logic                    w_own1;
    logic                    w_g0;
    logic                    w_g1;
    logic                    w_req_stb;
    logic                    w_resp;
    logic                    w_chg;
    logic                    w_expired;
    logic [ADDR_WIDTH-1:0]   w_adr;
    logic [DATA_WIDTH-1:0]   w_dat;
    logic [SELECT_WIDTH-1:0] w_sel;
    assign w_own0    = r_state == OWN0;
    assign w_own1    = r_state == OWN1;
    // a grant is live only while the owner still holds cyc; this gives the bubble cycle on release
    assign w_g0      = w_own0 & m0.cyc;
    assign w_g1      = w_own1 & m1.cyc;
    assign w_adr     = w_own0 ? m0.adr : w_own1 ? m1.adr : '0;
    assign w_dat     = w_own0 ? m0.dat_w : w_own1 ? m1.dat_w : '0;
    assign w_sel     = w_own0 ? m0.sel : w_own1 ? m1.sel : '0;
    assign w_req_stb = (w_g0 & m0.stb) | (w_g1 & m1.stb);
    assign w_resp    = s.ack | s.err | s.rty;
    assign w_chg     = (r_state == IDLE) ? (m0.cyc | m1.cyc) : ~(w_g0 | w_g1);
    assign s.adr     = w_adr;
    assign s.dat_w   = w_dat;
    assign s.sel     = w_sel;
    assign s.we      = w_own0 ? m0.we : (w_own1 & m1.we);
    assign s.cyc     = w_g0 | w_g1;
    assign s.stb     = w_req_stb & ~w_expired;
    assign m0.dat_r  = w_g0 ? s.dat_r : '0;
    assign m0.ack    = w_g0 & s.ack;
    assign m0.err    = w_g0 & (s.err | w_expired);
    assign m0.rty    = w_g0 & s.rty;
    assign m1.dat_r  = w_g1 ? s.dat_r : '0;
    assign m1.ack    = w_g1 & s.ack;
    assign m1.err    = w_g1 & (s.err | w_expired);
    assign m1.rty    = w_g1 & s.rty;
    wb_arb_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .active  (w_req_stb),
        .resp    (w_resp),
        .clr     (w_chg),
        .expired (w_expired)
    );
    // r_last resets to 1 so master 0 wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: r_state <= (m0.cyc & m1.cyc) ? (r_last ? OWN0 : OWN1) : m0.cyc ? OWN0 : m1.cyc ? OWN1 : IDLE;
                OWN0: if (!m0.cyc) begin
                    r_state <= IDLE;
                    r_last  <= 1'b0;
                end
                OWN1: if (!m1.cyc) begin
                    r_state <= IDLE;
                    r_last  <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
